// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and shift-amount width helper
// for the pipelined ALU and its iterative multiplier.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Number of low operand-B bits used as the shift amount.
  function automatic int alu_shw(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per cycle over WIDTH cycles.
// o_done/o_prod are valid combinationally in the final iteration cycle.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_busy;

  assign w_busy     = (r_cnt != '0);
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // The last iteration's sum is handed out directly so the caller can
  // register it on the same edge the counter reaches zero.
  assign o_done = (r_cnt == CW'(1));
  assign o_prod = w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= {{WIDTH{1'b0}}, i_b};
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH);
    end else if (w_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops finish
// in one cycle, MUL optionally iterates through alu_mul_iter.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_in_a,
  input  logic [WIDTH-1:0] alu_in_b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry,
  output logic             overflow,
  output logic             out_zero,
  output logic             out_equal
);

  localparam int SHW = alu_shw(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_alu_out;
  logic             r_carry;
  logic             r_overflow;
  logic             r_zero;
  logic             r_equal;
  logic             r_eq_pend;

  logic             w_accept;
  logic             w_is_mul_iter;
  logic             w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_shl;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  assign in_ready      = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
  assign out_valid     = (r_state == ST_HOLD);
  assign w_accept      = in_valid && in_ready;
  assign w_is_mul_iter = (opcode == OP_MUL) && (MUL_EN != 0);

  assign alu_out   = r_alu_out;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign out_zero  = r_zero;
  assign out_equal = r_equal;

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept && w_is_mul_iter),
        .i_a     (alu_in_a),
        .i_b     (alu_in_b),
        .o_done  (w_mul_done),
        .o_prod  (w_mul_prod)
      );
    end else begin : g_no_mul
      assign w_mul_done = 1'b0;
      assign w_mul_prod = '0;
    end
  endgenerate

  assign w_sh   = alu_in_b[SHW-1:0];
  assign w_sum  = {1'b0, alu_in_a} + {1'b0, alu_in_b};
  assign w_diff = {1'b0, alu_in_a} - {1'b0, alu_in_b};
  // The extra top bit catches the last bit shifted out (0 for a zero shift).
  assign w_shl  = {1'b0, alu_in_a} << w_sh;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (alu_in_a[MSB] == alu_in_b[MSB]) && (w_sum[MSB] != alu_in_a[MSB]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (alu_in_a[MSB] != alu_in_b[MSB]) && (w_diff[MSB] != alu_in_a[MSB]);
      end
      OP_MUL: begin
        w_res   = '0;
        w_carry = 1'b0;
      end
      OP_SHL: begin
        w_res   = w_shl[WIDTH-1:0];
        w_carry = w_shl[WIDTH];
      end
      OP_AND:  w_res = alu_in_a & alu_in_b;
      OP_XOR:  w_res = alu_in_a ^ alu_in_b;
      OP_OR:   w_res = alu_in_a | alu_in_b;
      OP_PASS: w_res = alu_in_b;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_accept) begin
          w_state_next = w_is_mul_iter ? ST_BUSY : ST_HOLD;
        end else if ((r_state == ST_HOLD) && out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_mul_done) begin
          w_state_next = ST_HOLD;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out  <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_equal    <= 1'b0;
      r_eq_pend  <= 1'b0;
    end else begin
      if (w_accept && !w_is_mul_iter) begin
        r_alu_out  <= w_res;
        r_carry    <= w_carry;
        r_overflow <= w_ovf;
        r_zero     <= (w_res == '0);
        r_equal    <= (alu_in_a == alu_in_b);
      end else if ((r_state == ST_BUSY) && w_mul_done) begin
        r_alu_out  <= w_mul_prod[WIDTH-1:0];
        r_carry    <= |w_mul_prod[2*WIDTH-1:WIDTH];
        r_overflow <= 1'b0;
        r_zero     <= (w_mul_prod[WIDTH-1:0] == '0);
        r_equal    <= r_eq_pend;
      end
      // Operand equality must survive the multiply, since inputs may change.
      if (w_accept) begin
        r_eq_pend <= (alu_in_a == alu_in_b);
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=8 with the iterative multiplier.
module tb_alu_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_in_a;
  logic [7:0] alu_in_b;
  logic [2:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_out;
  logic       carry;
  logic       overflow;
  logic       out_zero;
  logic       out_equal;

  int checks;
  int errors;

  alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_in_a  (alu_in_a),
    .alu_in_b  (alu_in_b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .carry     (carry),
    .overflow  (overflow),
    .out_zero  (out_zero),
    .out_equal (out_equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {alu_out, carry, overflow, out_zero, out_equal}
  function automatic logic [11:0] res_vec();
    return {alu_out, carry, overflow, out_zero, out_equal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle op with out_ready=1: result must appear exactly one cycle after accept.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] e_out, input logic e_c,
                        input logic e_v, input logic e_z, input logic e_e);
    opcode = op; alu_in_a = a; alu_in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_nvalid"}, {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    alu_in_a = 8'h5C; alu_in_b = 8'hC5;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"}, {20'd0, res_vec()}, {20'd0, e_out, e_c, e_v, e_z, e_e});
    $display("op %s a=%02h b=%02h -> out=%02h c=%0b v=%0b z=%0b e=%0b",
             tag, a, b, alu_out, carry, overflow, out_zero, out_equal);
    tick();
    chk({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  // MUL: checks in_ready low through BUSY and the accept-to-valid latency.
  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] e_out, input logic e_c, input logic e_z,
                         input logic e_e);
    int n;
    int busy_bad;
    opcode = 3'b010; alu_in_a = a; alu_in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    alu_in_a = 8'hFF; alu_in_b = 8'hFF; opcode = 3'b000;
    n = 1;
    busy_bad = 0;
    while (!out_valid && n < 20) begin
      if (in_ready !== 1'b0) busy_bad++;
      tick();
      n++;
    end
    chk({tag, "_busy_ready"}, busy_bad, 0);
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_res"}, {20'd0, res_vec()}, {20'd0, e_out, e_c, 1'b0, e_z, e_e});
    $display("op %s a=%02h b=%02h -> out=%02h c=%0b latency=%0d", tag, a, b, alu_out, carry, n);
    tick();
    chk({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int hold_bad;
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_in_a = '0; alu_in_b = '0; opcode = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", {20'd0, res_vec()}, 32'd0);
    $display("reset released");

    run_op("add_carry", 3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf",   3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("sub_zero",  3'b001, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op("sub_borrow",3'b001, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf",   3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("shl_1",     3'b011, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("shl_0",     3'b011, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("shl_7",     3'b011, 8'h03, 8'h07, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("and",       3'b100, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("pass",      3'b111, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    run_mul("mul_hi", 8'h12, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
    run_mul("mul_lo", 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b1);

    // Back-pressure: OR result held while a pending XOR waits for out_ready.
    opcode = 3'b110; alu_in_a = 8'h0F; alu_in_b = 8'hF0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    opcode = 3'b101; alu_in_a = 8'hAA; alu_in_b = 8'hAA; in_valid = 1'b1;
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_out !== 8'hFF) hold_bad++;
      if (i < 4) tick();
    end
    chk("bp_hold", hold_bad, 0);
    chk("bp_res", {20'd0, res_vec()}, {20'd0, 8'hFF, 4'b0000});
    $display("op or held 5 cycles -> out=%02h", alu_out);
    out_ready = 1'b1;
    #1;
    chk("bp_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_xor_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_xor_res", {20'd0, res_vec()}, {20'd0, 8'h00, 4'b0011});
    $display("op xor a=aa b=aa -> out=%02h z=%0b", alu_out, out_zero);
    tick();
    chk("bp_idle", {31'd0, out_valid}, 32'd0);

    // Load a nonzero held result so the reset clear is observable.
    run_op("or_pre", 3'b110, 8'h30, 8'h03, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in BUSY cycle 4 with in_valid asserted (must be ignored).
    opcode = 3'b010; alu_in_a = 8'h12; alu_in_b = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("mid_busy_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; in_valid = 1'b1; opcode = 3'b000; alu_in_a = 8'h03; alu_in_b = 8'h04;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_res", {20'd0, res_vec()}, 32'd0);
    $display("reset during multiply");
    run_op("add_after", 3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (12) tick();
    chk("no_residue_valid", {31'd0, out_valid}, 32'd0);
    chk("no_residue_out", {24'd0, alu_out}, 32'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
